// File: rtl/ex_div_pkg.sv
// Shared types for the EX-stage iterative divider: stall bus values,
// divider FSM encodings and result bus width.
package ex_div_pkg;

  typedef logic StallBus;

  localparam StallBus Stop   = 1'b1;
  localparam StallBus NoStop = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam int DivResultBus = 64;
  localparam int DivCntW      = 6;

endpackage

// File: rtl/ex_div_if.sv
// EX-stage <-> divider handshake: the EX stage is the master, the divider the slave.
interface ex_div_if
  import ex_div_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               cancel;
  logic               ready;
  logic [2*WIDTH-1:0] result;
  StallBus            stallreq_for_ex;

  modport master (
    output start, is_signed, dividend, divisor, cancel,
    input  ready, result, stallreq_for_ex
  );

  modport slave (
    input  start, is_signed, dividend, divisor, cancel,
    output ready, result, stallreq_for_ex
  );

endinterface

// File: rtl/ex_div_step.sv
// One restoring division iteration: compare the shifted partial remainder
// against the divisor, subtract when it fits, and emit the quotient bit.
module ex_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // The remainder always stays below the divisor, so WIDTH bits suffice after subtracting.
  assign q_bit    = (partial >= {1'b0, divisor});
  assign rem_next = q_bit ? (partial[WIDTH-1:0] - divisor) : partial[WIDTH-1:0];

endmodule

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU. Stalls the EX stage
// until {remainder, quotient} is ready for the HI/LO write path.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  bus
);

  div_state_e         state;
  logic [DivCntW-1:0] cnt;
  logic               ready_r;
  logic               ready;

  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic               q_neg;
  logic               r_neg;

  logic [WIDTH-1:0]   rem_nxt;
  logic               q_bit;
  logic               accept;
  logic               dvs_zero;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (sgn && (sv < 0)) ? $unsigned(-sv) : v;
  endfunction

  function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return neg ? $unsigned(-sv) : v;
  endfunction

  assign accept   = (state == DivFree) && bus.start && !bus.cancel;
  assign dvs_zero = (bus.divisor == '0);

  ex_div_step #(.WIDTH(WIDTH)) u_step (
    .partial  ({rem, quo[WIDTH-1]}),
    .divisor  (dvs),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  // Control: state, iteration counter and the registered completion flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DivFree;
      cnt     <= '0;
      ready_r <= 1'b0;
    end else if (bus.cancel) begin
      state   <= DivFree;
      cnt     <= '0;
      ready_r <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      case (state)
        DivFree: begin
          cnt <= '0;
          if (bus.start) state <= dvs_zero ? DivByZero : DivOn;
        end
        DivByZero: begin
          state   <= DivEnd;
          ready_r <= 1'b1;
        end
        DivOn: begin
          if (cnt == DivCntW'(WIDTH - 1)) begin
            state   <= DivEnd;
            cnt     <= '0;
            ready_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DivEnd:  state <= DivFree;
        default: state <= DivFree;
      endcase
    end
  end

  // Datapath: magnitudes and sign flags captured at accept, one step per ON cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem   <= '0;
      dvs   <= abs_val(bus.divisor, bus.is_signed);
      quo   <= dvs_zero ? '0 : abs_val(bus.dividend, bus.is_signed);
      q_neg <= bus.is_signed && !dvs_zero && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      r_neg <= bus.is_signed && !dvs_zero && bus.dividend[WIDTH-1];
    end else if (state == DivOn) begin
      rem <= rem_nxt;
      quo <= {quo[WIDTH-2:0], q_bit};
    end
  end

  assign ready               = ready_r && !bus.cancel;
  assign bus.ready           = ready;
  assign bus.result          = (state == DivEnd) ? {sign_fix(rem, r_neg), sign_fix(quo, q_neg)} : '0;
  assign bus.stallreq_for_ex = (bus.start && !ready) ? Stop : NoStop;

endmodule

// File: tb/tb_ex_div.sv
// Directed-vector bench for ex_div: latency, stall length, signed/unsigned
// results, divide by zero, overflow, cancel, mid-operation reset and back-to-back ops.
module tb_ex_div;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ex_div_if #(.WIDTH(32)) bus ();

  ex_div #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one op at cycle 0, scrambles operands afterwards, waits for ready.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int          stall_n;
    int          rdy_at;
    int          bad_res;
    logic [63:0] res_at;
    res_at  = '0;
    bad_res = 0;
    tick();
    bus.start     = 1'b1;
    bus.cancel    = 1'b0;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(negedge clk);
    stall_n = int'(bus.stallreq_for_ex);
    rdy_at  = bus.ready ? 0 : -1;
    for (int c = 1; c <= 40 && rdy_at < 0; c++) begin
      tick();
      bus.dividend  = $urandom;
      bus.divisor   = $urandom;
      bus.is_signed = ~sgn;
      @(negedge clk);
      stall_n += int'(bus.stallreq_for_ex);
      if (bus.ready) begin
        rdy_at = c;
        res_at = bus.result;
      end else if (bus.result != '0) begin
        bad_res++;
      end
    end
    check_val({tag, "_latency"}, 64'(rdy_at), 64'(exp_lat));
    check_val({tag, "_result"}, res_at, exp_res);
    check_val({tag, "_stall_cycles"}, 64'(stall_n), 64'(exp_lat));
    check_val({tag, "_result_zero_outside_end"}, 64'(bad_res), 64'd0);
  endtask

  task automatic end_op(input string tag);
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    check_val({tag, "_ready_one_cycle"}, 64'(bus.ready), 64'd0);
  endtask

  initial begin
    int rdy_cnt;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.cancel    = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) tick();
    @(negedge clk);
    check_val("reset_ready", 64'(bus.ready), 64'd0);
    check_val("reset_result", bus.result, 64'd0);
    check_val("reset_stall_idle", 64'(bus.stallreq_for_ex), 64'd0);
    bus.start = 1'b1;
    #1;
    check_val("reset_stall_follows_start", 64'(bus.stallreq_for_ex), 64'd1);
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    end_op("divu_100_7");
    do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    end_op("div_m7_2");
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    end_op("div_7_m2");
    do_div("divu_fff9_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 33);
    end_op("divu_fff9_2");
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'h0, 2);
    end_op("divu_5_0");
    do_div("div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 64'h0, 2);
    end_op("div_m5_0");
    do_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    end_op("div_ovf");
    do_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);
    end_op("divu_max_1");

    // Cancel at cycle 10, then a fresh op accepted at cycle 11 must finish 33 cycles later.
    tick();
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd3;
    @(negedge clk);
    rdy_cnt = int'(bus.ready);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 10) bus.cancel = 1'b1;
      @(negedge clk);
      rdy_cnt += int'(bus.ready);
    end
    check_val("cancel_no_ready", 64'(rdy_cnt), 64'd0);
    do_div("after_cancel", 1'b0, 32'd20, 32'd6, 64'h00000002_00000003, 33);
    end_op("after_cancel");

    // Reset at cycle 20 discards the operation.
    tick();
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd7;
    for (int c = 1; c <= 19; c++) tick();
    tick();
    rst       = 1'b1;
    bus.start = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("midreset_ready", 64'(bus.ready), 64'd0);
    check_val("midreset_result", bus.result, 64'd0);
    check_val("midreset_stall", 64'(bus.stallreq_for_ex), 64'd0);
    rdy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      @(negedge clk);
      rdy_cnt += int'(bus.ready);
    end
    check_val("midreset_no_late_ready", 64'(rdy_cnt), 64'd0);

    // Back-to-back with start held: second op accepted in the cycle after END.
    do_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);
    do_div("b2b_10_4", 1'b0, 32'd10, 32'd4, 64'h00000002_00000002, 33);
    end_op("b2b_10_4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
